// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the IF stage: instruction format, opcodes and
// the next-PC selection encoding.
package instr_fetch_stage_pkg;

  localparam int unsigned INTERNAL_BITS = 16;

  // Opcode field and jump-address field positions within an instruction
  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 12;
  localparam int unsigned JADDR_MSB = 11;
  localparam int unsigned JADDR_LSB = 0;
  localparam int unsigned JADDR_W   = JADDR_MSB - JADDR_LSB + 1;

  typedef logic [INTERNAL_BITS-1:0] instr_t;

  localparam logic [3:0] OP_JMP    = 4'hA;
  localparam instr_t     HLT_INSTR = 16'hF000;
  localparam instr_t     NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    SEL_INC   = 2'd0,
    SEL_HOLD  = 2'd1,
    SEL_JUMP  = 2'd2,
    SEL_FLUSH = 2'd3
  } pc_sel_e;

  function automatic logic [3:0] opcode(input instr_t ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [JADDR_W-1:0] jaddr(input instr_t ins);
    return ins[JADDR_MSB:JADDR_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_sel.sv
// Combinational next-PC mux: flush target, hold, jump target or increment.
module fetch_pc_sel
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic            flush,
  input  logic            hold,
  input  logic [PC_W-1:0] branch_target,
  input  instr_t          im_rdata,
  output logic [PC_W-1:0] next_pc,
  output logic            is_hlt,
  output pc_sel_e         sel
);

  // Priority: flush > hold > jump > halt (pc held) > increment
  always_comb begin
    is_hlt  = (im_rdata == HLT_INSTR);
    sel     = SEL_INC;
    next_pc = pc + PC_W'(1);
    if (flush) begin
      sel     = SEL_FLUSH;
      next_pc = branch_target;
    end else if (hold || is_hlt) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end else if (opcode(im_rdata) == OP_JMP) begin
      sel     = SEL_JUMP;
      next_pc = PC_W'(jaddr(im_rdata));
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: PC register, instruction-memory address, IF/ID latch,
// HLT freeze flag and saturating fetch counter.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     IF_flush,
  input  logic [PC_W-1:0]          branch_target,
  input  logic                     done,
  output logic [PC_W-1:0]          im_addr,
  input  logic [INTERNAL_BITS-1:0] im_rdata,
  output logic [INTERNAL_BITS-1:0] Instruction,
  output logic [PC_W-1:0]          ifid_pc1,
  output logic                     ifid_valid,
  output logic                     halted,
  output logic [CNT_W-1:0]         fetch_count
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_pc;
  logic            hold;
  logic            is_hlt;
  pc_sel_e         sel;

  assign hold    = done | halted | stall;
  assign im_addr = pc;

  fetch_pc_sel #(
    .PC_W (PC_W)
  ) u_pc_sel (
    .pc            (pc),
    .flush         (IF_flush),
    .hold          (hold),
    .branch_target (branch_target),
    .im_rdata      (im_rdata),
    .next_pc       (next_pc),
    .is_hlt        (is_hlt),
    .sel           (sel)
  );

  // PC, IF/ID latch, halt flag and counter; flush outranks every hold source
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= PC_W'(RESET_PC);
      Instruction <= NOP_INSTR;
      ifid_pc1    <= '0;
      ifid_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= next_pc;
      if (sel == SEL_FLUSH) begin
        Instruction <= NOP_INSTR;
        ifid_pc1    <= '0;
        ifid_valid  <= 1'b0;
        halted      <= 1'b0;
      end else if (!hold) begin
        Instruction <= im_rdata;
        ifid_pc1    <= pc + PC_W'(1);
        ifid_valid  <= 1'b1;
        if (is_hlt)
          halted <= 1'b1;
        if (fetch_count != '1)
          fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: table-driven main sequence on an
// 8-bit PC instance, plus hand-written async-reset and PC_W=4/CNT_W=2 checks.
module tb_instr_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance (PC_W=8, CNT_W=16)
  logic        rst, stall, IF_flush, done;
  logic [7:0]  branch_target, im_addr, ifid_pc1;
  logic [15:0] im_rdata, Instruction, fetch_count;
  logic        ifid_valid, halted;
  logic [15:0] mem [256];
  assign im_rdata = mem[im_addr];

  instr_fetch_stage #(.PC_W(8), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .IF_flush(IF_flush),
    .branch_target(branch_target), .done(done), .im_addr(im_addr),
    .im_rdata(im_rdata), .Instruction(Instruction), .ifid_pc1(ifid_pc1),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
  );

  // Narrow instance (PC_W=4, CNT_W=2)
  logic        rst2;
  logic [3:0]  im_addr2, ifid_pc1_2;
  logic [15:0] im_rdata2, Instruction2;
  logic        ifid_valid2, halted2;
  logic [1:0]  fetch_count2;
  logic [15:0] mem2 [16];
  assign im_rdata2 = mem2[im_addr2];

  instr_fetch_stage #(.PC_W(4), .RESET_PC(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .stall(1'b0), .IF_flush(1'b0),
    .branch_target(4'h0), .done(1'b0), .im_addr(im_addr2),
    .im_rdata(im_rdata2), .Instruction(Instruction2), .ifid_pc1(ifid_pc1_2),
    .ifid_valid(ifid_valid2), .halted(halted2), .fetch_count(fetch_count2)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        done;
    logic [7:0]  tgt;
    logic [15:0] instr;
    logic [7:0]  pc1;
    logic        valid;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic f, input logic d, input logic [7:0] t,
                     input logic [15:0] ins, input logic [7:0] p1, input logic v,
                     input logic [7:0] p, input logic h, input logic [15:0] c);
    vec_t e;
    e.stall = s; e.flush = f; e.done = d; e.tgt = t;
    e.instr = ins; e.pc1 = p1; e.valid = v; e.pc = p; e.halted = h; e.cnt = c;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_main(input string tag, input vec_t e);
    check({tag, " Instruction"}, 32'(Instruction), 32'(e.instr));
    check({tag, " ifid_pc1"},    32'(ifid_pc1),    32'(e.pc1));
    check({tag, " ifid_valid"},  32'(ifid_valid),  32'(e.valid));
    check({tag, " im_addr"},     32'(im_addr),     32'(e.pc));
    check({tag, " halted"},      32'(halted),      32'(e.halted));
    check({tag, " fetch_count"}, 32'(fetch_count), 32'(e.cnt));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t rst_exp;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[5] = 16'hA010;  // JMP 0x10
    mem[7] = 16'hF000;  // HLT
    for (int i = 0; i < 16; i++) mem2[i] = 16'h2000 + 16'(i);

    rst = 1'b0; rst2 = 1'b0;
    stall = 1'b0; IF_flush = 1'b0; done = 1'b0; branch_target = 8'h00;

    rst_exp = '{stall:0, flush:0, done:0, tgt:8'h00, instr:16'h0000, pc1:8'h00,
                valid:0, pc:8'h00, halted:0, cnt:16'd0};
    #2;
    check_main("reset", rst_exp);
    @(posedge clk); #1;
    rst = 1'b1;

    //   stall flush done tgt    instr     pc1    v  pc     h  cnt
    add(0, 0, 0, 8'h00, 16'h1000, 8'h01, 1, 8'h01, 0, 16'd1);
    add(0, 0, 0, 8'h00, 16'h1001, 8'h02, 1, 8'h02, 0, 16'd2);
    for (int i = 0; i < 3; i++)
      add(1, 0, 0, 8'h00, 16'h1001, 8'h02, 1, 8'h02, 0, 16'd2);
    add(0, 0, 0, 8'h00, 16'h1002, 8'h03, 1, 8'h03, 0, 16'd3);
    add(0, 0, 0, 8'h00, 16'h1003, 8'h04, 1, 8'h04, 0, 16'd4);
    add(0, 0, 0, 8'h00, 16'h1004, 8'h05, 1, 8'h05, 0, 16'd5);
    add(0, 0, 0, 8'h00, 16'hA010, 8'h06, 1, 8'h10, 0, 16'd6);
    add(0, 0, 0, 8'h00, 16'h1010, 8'h11, 1, 8'h11, 0, 16'd7);
    add(1, 1, 0, 8'h40, 16'h0000, 8'h00, 0, 8'h40, 0, 16'd7);
    add(0, 0, 0, 8'h00, 16'h1040, 8'h41, 1, 8'h41, 0, 16'd8);
    add(0, 1, 0, 8'h07, 16'h0000, 8'h00, 0, 8'h07, 0, 16'd8);
    add(0, 0, 0, 8'h00, 16'hF000, 8'h08, 1, 8'h07, 1, 16'd9);
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 8'h00, 16'hF000, 8'h08, 1, 8'h07, 1, 16'd9);
    add(0, 1, 1, 8'h20, 16'h0000, 8'h00, 0, 8'h20, 0, 16'd9);
    add(0, 0, 1, 8'h00, 16'h0000, 8'h00, 0, 8'h20, 0, 16'd9);
    add(0, 0, 0, 8'h00, 16'h1020, 8'h21, 1, 8'h21, 0, 16'd10);
    add(0, 0, 1, 8'h00, 16'h1020, 8'h21, 1, 8'h21, 0, 16'd10);

    foreach (vecs[i]) begin
      stall = vecs[i].stall; IF_flush = vecs[i].flush;
      done = vecs[i].done; branch_target = vecs[i].tgt;
      step();
      check_main($sformatf("vec%0d", i), vecs[i]);
    end
    stall = 1'b0; IF_flush = 1'b0; done = 1'b0; branch_target = 8'h00;

    // Asynchronous reset mid-cycle, away from any clock edge
    step();
    #2;
    rst = 1'b0;
    #1;
    check_main("async_rst", rst_exp);
    step();
    check_main("rst_held", rst_exp);
    rst = 1'b1;
    step();
    check("post_rst Instruction", 32'(Instruction), 32'h1000);
    check("post_rst im_addr",     32'(im_addr),     32'h01);

    // Narrow instance: PC wraps at 0xF, counter saturates at 3
    rst2 = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      step();
      if (n == 3) check("w4 cnt at 3", 32'(fetch_count2), 32'd3);
      if (n == 4) check("w4 cnt sat", 32'(fetch_count2), 32'd3);
      if (n == 15) check("w4 pc1 at E", 32'(ifid_pc1_2), 32'hF);
      if (n == 16) begin
        check("w4 pc wrap",  32'(im_addr2),     32'h0);
        check("w4 pc1 wrap", 32'(ifid_pc1_2),   32'h0);
        check("w4 instr F",  32'(Instruction2), 32'h200F);
        check("w4 cnt sat2", 32'(fetch_count2), 32'd3);
      end
      if (n == 17) begin
        check("w4 instr 0", 32'(Instruction2), 32'h2000);
        check("w4 pc 1",    32'(im_addr2),     32'h1);
        check("w4 valid",   32'(ifid_valid2),  32'd1);
        check("w4 halted",  32'(halted2),      32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
